dma_register_programmer: RTL
============================

Name: dma_register_programmer

Overview:
- Host-side bus initiator that programs and interrogates the 8237-style DMA controller through its slave register port.
- Turns single-word requests (write command, write mode, program channel, read status/address/count, clear flip-flop) into correctly timed CS_N/IOR_N/IOW_N/A3..A0/data-bus cycles.
- Handles the byte-pointer flip-flop for 16-bit registers.
- Sits between the testbench/CPU model and the controller's bus interface; yields the bus whenever the controller holds it (HLDA).

Parameters:
STROBE_CYCLES, 2, clock cycles IOR_N/IOW_N held low per bus cycle (legal range 1..15)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET_N  input  1  reset, asynchronous assert, active-low
REQ_VALID  input  1  request present
REQ_READY  output  1  block accepts request this cycle
REQ_OP  input  3  0 WR_CMD, 1 WR_MODE, 2 PROGRAM_CH, 3 RD_STATUS, 4 RD_ADDR, 5 RD_COUNT, 6 CLR_FF, 7 reserved
REQ_CH  input  2  channel select for ops 2,4,5
REQ_ADDR  input  16  base address for PROGRAM_CH
REQ_COUNT  input  16  base word count for PROGRAM_CH
REQ_DATA  input  8  byte for WR_CMD/WR_MODE, sent verbatim
RSP_VALID  output  1  one-cycle completion pulse
RSP_DATA  output  16  read result; 0 for write ops
BUSY  output  1  request in progress
HLDA  input  1  controller owns bus; no new bus cycle may start
CS_N  output  1  chip select
IOR_N  output  1  read strobe
IOW_N  output  1  write strobe
A  output  4  register address A3..A0
DB_OUT  output  8  write data
DB_OE  output  1  write-data drive enable
DB_IN  input  8  read data from controller

Behaviour:
- Reset (async, immediate): CS_N=IOR_N=IOW_N=1, A=0, DB_OUT=0, DB_OE=0, REQ_READY=0, RSP_VALID=0, RSP_DATA=0, BUSY=0, state IDLE.
- REQ_READY is registered and rises on the first clock after reset release.
- Reset mid-operation aborts the sequence with no completion pulse.
- Handshake: a request is accepted on an edge where REQ_VALID & REQ_READY.
  - All REQ_* fields are latched at acceptance.
  - REQ_READY=0 and BUSY=1 from the following cycle until the cycle after RSP_VALID.
  - REQ_VALID while not ready is ignored.
- Bus-cycle sequences (A codes shown as A3..A0):
  - WR_CMD: write 1000.
  - WR_MODE: write 1011.
  - CLR_FF: write 1100, data 0x00.
  - RD_STATUS: read 1000.
  - PROGRAM_CH: write 1100 (clear FF), then 0,ch,0 with ADDR[7:0], then ADDR[15:8], then 0,ch,1 with COUNT[7:0], then COUNT[15:8]. Five cycles total.
  - RD_ADDR / RD_COUNT: write 1100, then read 0,ch,0 (or 0,ch,1) for the low byte, then the same address for the high byte.
  - Op 7: no bus activity; RSP_VALID pulses the cycle after acceptance with RSP_DATA=0.
- Single bus-cycle timing: states SETUP → STROBE → HOLD → GAP.
  - SETUP (1 cycle): CS_N=0; A valid; for writes DB_OE=1 and DB_OUT valid.
  - STROBE (STROBE_CYCLES cycles): IOW_N=0 or IOR_N=0.
  - HOLD (1 cycle): strobe=1; CS_N, A, DB unchanged.
  - GAP (1 cycle): CS_N=1, DB_OE=0, A unchanged.
  - One bus cycle = STROBE_CYCLES+3 clocks.
- Read capture: DB_IN is sampled on the edge ending the last STROBE cycle. The low byte goes to RSP_DATA[7:0], the high byte to [15:8]. RD_STATUS zero-extends.
- Completion: RSP_VALID=1 during the GAP of the final bus cycle, with RSP_DATA valid in that cycle. IDLE and REQ_READY=1 follow on the next cycle.
- HLDA:
  - Sampled only where a new SETUP would begin: the cycle after acceptance, or the cycle after a non-final GAP.
  - If HLDA=1, enter WAIT with all bus outputs idle and BUSY=1; SETUP starts the cycle after HLDA is seen 0.
  - A bus cycle already in SETUP/STROBE/HOLD always completes.
- Invariants:
  - IOR_N and IOW_N are never both 0.
  - A strobe is never 0 while CS_N=1.
  - A and DB_OUT are stable from SETUP through HOLD.
  - DB_OE is never 1 during a read cycle.
- Latency with STROBE_CYCLES=2, HLDA=0: RSP_VALID at cycle 5 after acceptance for a single bus cycle. PROGRAM_CH takes 25 cycles; RD_ADDR/RD_COUNT take 15.

Test Plan:
- Reset, then WR_CMD REQ_DATA=0x44 → one cycle at A=1000: DB_OUT=0x44, IOW_N low exactly 2 clocks, RSP_VALID at cycle 5, RSP_DATA=0; afterwards CS_N=1 and DB_OE=0.
- PROGRAM_CH ch=2, ADDR=0x1234, COUNT=0x00FF → writes in order: (1100,0x00), (0100,0x34), (0100,0x12), (0101,0xFF), (0101,0x00); RSP_VALID at cycle 25.
- RD_COUNT ch=1 with responder returning 0xCD then 0xAB → FF clear at 1100, then two reads at 0011; RSP_DATA=0xABCD, DB_OE=0 throughout both reads.
- HLDA asserted during the 2nd bus cycle of PROGRAM_CH, held 10 cycles → 2nd cycle completes; CS_N=1 and BUSY=1 for the stall; remaining 3 cycles then resume; final data correct.
- RESET_N pulsed low mid-STROBE of RD_STATUS → all bus outputs idle immediately, no RSP_VALID; the next WR_MODE 0x56 executes normally at A=1011.
- Back-to-back CLR_FF and op 7 with REQ_VALID held high → second request accepted in the cycle after the first RSP_VALID; op 7 gives RSP_VALID one cycle later with no CS_N activity.
- Sweep STROBE_CYCLES=1 and 15 → strobe width matches exactly; strobe-exclusivity assertion holds across all tests.

Source files
------------

// File: rtl/dma_register_programmer.sv
// dma_register_programmer: host-side bus initiator for an 8237-style DMA
// controller slave port. Converts single-word requests into CS_N/IOR_N/IOW_N
// register cycles (SETUP, STROBE x STROBE_CYCLES, HOLD, GAP), manages the
// byte-pointer flip-flop for 16-bit registers and yields the bus while HLDA=1.
// Ports:
//   CLK, RESET_N                     clock, async active-low reset
//   REQ_VALID/REQ_READY              request handshake
//   REQ_OP/CH/ADDR/COUNT/DATA        request fields, latched at acceptance
//   RSP_VALID/RSP_DATA, BUSY         completion pulse, read result, activity
//   HLDA                             controller owns bus, hold off new cycles
//   CS_N/IOR_N/IOW_N/A/DB_OUT/DB_OE  slave register bus drive
//   DB_IN                            slave register read data
module dma_register_programmer #(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_OP,
  input  logic [1:0]  REQ_CH,
  input  logic [15:0] REQ_ADDR,
  input  logic [15:0] REQ_COUNT,
  input  logic [7:0]  REQ_DATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        BUSY,
  input  logic        HLDA,
  output logic        CS_N,
  output logic        IOR_N,
  output logic        IOW_N,
  output logic [3:0]  A,
  output logic [7:0]  DB_OUT,
  output logic        DB_OE,
  input  logic [7:0]  DB_IN
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned DEC_W  = 14;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_WAIT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          ch_q, ch_d;
  logic [15:0]         addr_q, addr_d, count_q, count_d;
  logic [7:0]          data_q, data_d;
  logic                rd_q, rd_d, last_q, last_d;
  logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d, cs_n_q, cs_n_d, ior_n_q, ior_n_d;
  logic                iow_n_q, iow_n_d, db_oe_q, db_oe_d;
  logic [3:0]          a_q, a_d;
  logic [7:0]          db_out_q, db_out_d;
  logic                accept, start_setup, bus_act;
  logic [DEC_W-1:0]    dec;

  // Bus cycle 'step' of a request: {is_read, is_last, A3..A0, write byte}.
  function automatic logic [DEC_W-1:0] decode(
    input logic [2:0]  op,
    input logic [1:0]  ch,
    input logic [15:0] addr,
    input logic [15:0] cnt,
    input logic [7:0]  data,
    input logic [STEP_W-1:0] step
  );
    logic       rd;
    logic       last;
    logic [3:0] a;
    logic [7:0] d;
    rd   = 1'b0;
    last = 1'b1;
    a    = 4'b1100;  // flip-flop clear, data 0x00
    d    = 8'h00;
    case (op)
      3'd0: begin a = 4'b1000; d = data; end
      3'd1: begin a = 4'b1011; d = data; end
      3'd2: begin
        last = (step == 3'd4);
        case (step)
          3'd1:    begin a = {1'b0, ch, 1'b0}; d = addr[7:0];  end
          3'd2:    begin a = {1'b0, ch, 1'b0}; d = addr[15:8]; end
          3'd3:    begin a = {1'b0, ch, 1'b1}; d = cnt[7:0];   end
          3'd4:    begin a = {1'b0, ch, 1'b1}; d = cnt[15:8];  end
          default: ;
        endcase
      end
      3'd3: begin rd = 1'b1; a = 4'b1000; end
      3'd4, 3'd5: begin
        last = (step == 3'd2);
        if (step != 3'd0) begin
          rd = 1'b1;
          a  = {1'b0, ch, (op == 3'd5)};
        end
      end
      default: ;
    endcase
    return {rd, last, a, d};
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    count_d     = count_q;
    data_d      = data_q;
    rd_d        = rd_q;
    last_d      = last_q;
    a_d         = a_q;
    db_out_d    = db_out_q;
    rsp_data_d  = rsp_data_q;
    start_setup = 1'b0;
    accept      = REQ_VALID && req_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = REQ_OP;
          ch_d       = REQ_CH;
          addr_d     = REQ_ADDR;
          count_d    = REQ_COUNT;
          data_d     = REQ_DATA;
          step_d     = '0;
          rsp_data_d = '0;
          if (REQ_OP == 3'd7)  state_d = S_DONE;
          else if (HLDA)       state_d = S_WAIT;
          else                 start_setup = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_W'(STROBE_CYCLES - 1);
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          // Read data is taken on the edge that ends the strobe.
          if (rd_q) begin
            if (step_q == 3'd2) rsp_data_d[15:8] = DB_IN;
            else                rsp_data_d[7:0]  = DB_IN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD:  state_d = S_GAP;
      S_GAP: begin
        if (last_q) begin
          state_d = S_IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
          if (HLDA) state_d = S_WAIT;
          else      start_setup = 1'b1;
        end
      end
      S_WAIT:  if (!HLDA) start_setup = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Decode uses the post-transition fields so acceptance can launch SETUP.
    dec = decode(op_d, ch_d, addr_d, count_d, data_d, step_d);
    if (start_setup) begin
      state_d  = S_SETUP;
      rd_d     = dec[13];
      last_d   = dec[12];
      a_d      = dec[11:8];
      db_out_d = dec[7:0];
    end

    bus_act     = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d      = !bus_act;
    db_oe_d     = bus_act && !rd_d;
    ior_n_d     = !((state_d == S_STROBE) && rd_d);
    iow_n_d     = !((state_d == S_STROBE) && !rd_d);
    rsp_valid_d = ((state_d == S_GAP) && last_d) || (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      data_q      <= '0;
      rd_q        <= 1'b0;
      last_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      ior_n_q     <= 1'b1;
      iow_n_q     <= 1'b1;
      a_q         <= '0;
      db_out_q    <= '0;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      ior_n_q     <= ior_n_d;
      iow_n_q     <= iow_n_d;
      a_q         <= a_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign BUSY      = busy_q;
  assign CS_N      = cs_n_q;
  assign IOR_N     = ior_n_q;
  assign IOW_N     = iow_n_q;
  assign A         = a_q;
  assign DB_OUT    = db_out_q;
  assign DB_OE     = db_oe_q;

endmodule
